// File: rtl/down_sram_drain_reader.sv
// down_sram_drain_reader
//   Read-side master for the systolic array's output ("down") SRAM bank.
//   After a drain is launched it walks an inclusive address range, issues
//   one SRAM read per address, absorbs the 1-cycle read latency and delivers
//   each result row on a valid/ready stream. A credit rule over a 2-entry
//   buffer guarantees backpressure never drops or overwrites data.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   i_start         1-cycle launch pulse (ignored while busy)
//   i_start_addr    first address, sampled with i_start
//   i_end_addr      last address (inclusive), sampled with i_start
//   o_rd_en         SRAM read enable
//   o_rd_addr       SRAM read address (holds last value when idle)
//   i_rd_data       SRAM read data, valid the cycle after o_rd_en
//   o_valid/i_ready stream handshake
//   o_data          stream word
//   o_last          marks the final word of the range
//   o_busy          drain in progress
//   o_done          1-cycle pulse when the final word is accepted
//   o_err           1-cycle pulse when a launch had end < start
module down_sram_drain_reader #(
  parameter int NUM_COL              = 8,
  parameter int OUT_DATA_WIDTH       = 32,
  parameter int LOG2_SRAM_BANK_DEPTH = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_start,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0]   i_start_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0]   i_end_addr,
  output logic                              o_rd_en,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]   o_rd_addr,
  input  logic [NUM_COL*OUT_DATA_WIDTH-1:0] i_rd_data,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [NUM_COL*OUT_DATA_WIDTH-1:0] o_data,
  output logic                              o_last,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_err
);

  localparam int DW = NUM_COL * OUT_DATA_WIDTH;
  localparam int AW = LOG2_SRAM_BANK_DEPTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] end_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] last_addr_q;
  logic          inflight_q;
  logic          inflight_last_q;
  logic          err_q;

  // 2-entry result buffer
  logic          wr_idx_q;
  logic          rd_idx_q;
  logic [1:0]    count_q;
  logic [1:0]    count_d;

  logic          start_ok;
  logic          start_bad;
  logic          pop;
  logic          push;
  logic          head_last;
  logic [2:0]    credit_used;
  logic          rd_en;
  logic          issue_last;

  assign start_ok  = (state_q == IDLE) && i_start && (i_end_addr >= i_start_addr);
  assign start_bad = (state_q == IDLE) && i_start && (i_end_addr <  i_start_addr);

  assign o_valid = (count_q != 2'd0);
  assign pop     = o_valid && i_ready;
  assign push    = inflight_q;

  // Buffer slots already spoken for, crediting a pop happening this cycle.
  // A pop implies count_q >= 1, so the subtraction never underflows.
  assign credit_used = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign rd_en      = (state_q == READ) && (credit_used < 3'd2);
  // Equality (not a magnitude test) so an end of all-ones never lets the
  // wrapped pointer trigger another read.
  assign issue_last = rd_en && (rd_ptr_q == end_q);

  assign o_rd_en   = rd_en;
  assign o_rd_addr = rd_en ? rd_ptr_q : last_addr_q;
  assign o_busy    = (state_q == READ) || (state_q == FLUSH);
  assign o_done    = (state_q == DONE);
  assign o_err     = err_q;

  // Buffer storage, one register slot per entry
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [DW-1:0] data_q;
    logic          last_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q <= '0;
        last_q <= 1'b0;
      end else if (push && (wr_idx_q == gi[0])) begin
        data_q <= i_rd_data;
        last_q <= inflight_last_q;
      end
    end
  end

  assign o_data    = rd_idx_q ? g_entry[1].data_q : g_entry[0].data_q;
  assign head_last = rd_idx_q ? g_entry[1].last_q : g_entry[0].last_q;
  assign o_last    = o_valid && head_last;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = READ;
      READ:    if (issue_last) state_d = FLUSH;
      FLUSH:   if (pop && head_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      end_q           <= '0;
      rd_ptr_q        <= '0;
      last_addr_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      err_q           <= 1'b0;
      wr_idx_q        <= 1'b0;
      rd_idx_q        <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      state_q         <= state_d;
      err_q           <= start_bad;
      inflight_q      <= rd_en;
      inflight_last_q <= issue_last;
      count_q         <= count_d;
      if (push) wr_idx_q <= ~wr_idx_q;
      if (pop)  rd_idx_q <= ~rd_idx_q;
      if (start_ok) begin
        rd_ptr_q <= i_start_addr;
        end_q    <= i_end_addr;
      end else if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (rd_en) last_addr_q <= rd_ptr_q;
    end
  end

endmodule

// File: tb/tb_down_sram_drain_reader.sv
// Self-checking bench for down_sram_drain_reader: a behavioural SRAM with
// random contents, random stream backpressure, and per-scenario tasks that
// compare observed drains against the expected address/word sequence.
module tb_down_sram_drain_reader;

  localparam int NC = 8;
  localparam int OW = 32;
  localparam int AW = 10;
  localparam int DW = NC * OW;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [AW-1:0] i_start_addr;
  logic [AW-1:0] i_end_addr;
  logic          o_rd_en;
  logic [AW-1:0] o_rd_addr;
  logic [DW-1:0] i_rd_data;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // drain observation record
  int            rd_addrs [$];
  logic [DW-1:0] words    [$];
  logic          lasts    [$];
  int first_rd, first_val, done_cyc;
  int credit_viol, stable_viol, busy_viol, err_seen;

  down_sram_drain_reader #(
    .NUM_COL(NC), .OUT_DATA_WIDTH(OW), .LOG2_SRAM_BANK_DEPTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_start_addr(i_start_addr),
    .i_end_addr(i_end_addr), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .i_rd_data(i_rd_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_last(o_last), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int k = 0; k < NC; k++) w[k*OW +: OW] = $urandom;
    return w;
  endfunction

  // SRAM: 1-cycle read latency; garbage when no read was issued
  always @(posedge clk) begin
    if (o_rd_en) i_rd_data <= mem[o_rd_addr];
    else         i_rd_data <= rnd_word();
  end

  // Launch a drain in the next cycle and watch it until o_done (bounded).
  // rmode 0: ready held high; 1: random ready. Optionally pulses a second
  // i_start (inj_s..inj_e) at observed cycle inj_at.
  task automatic drain(input int sa, input int ea, input int rmode,
                       input int inj_at, input int inj_s, input int inj_e);
    int issued, accepted;
    logic prev_stall, prev_last;
    logic [DW-1:0] prev_data;
    rd_addrs.delete(); words.delete(); lasts.delete();
    first_rd = -1; first_val = -1; done_cyc = -1;
    credit_viol = 0; stable_viol = 0; busy_viol = 0; err_seen = 0;
    issued = 0; accepted = 0; prev_stall = 0; prev_last = 0; prev_data = '0;
    @(posedge clk); #1;
    i_start = 1'b1; i_start_addr = AW'(sa); i_end_addr = AW'(ea);
    i_ready = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      i_start = (n == inj_at);
      if (n == inj_at) begin
        i_start_addr = AW'(inj_s); i_end_addr = AW'(inj_e);
      end
      i_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (prev_stall && (!o_valid || o_data !== prev_data || o_last !== prev_last))
        stable_viol++;
      if (o_rd_en) begin
        rd_addrs.push_back(int'(o_rd_addr));
        if (first_rd < 0) first_rd = n;
        issued++;
      end
      if (o_valid && first_val < 0) first_val = n;
      if (o_err) err_seen++;
      if (!o_busy && !o_done) busy_viol++;
      if (o_valid && i_ready) begin
        words.push_back(o_data);
        lasts.push_back(o_last);
        accepted++;
      end
      if (issued - accepted > 2) credit_viol++;
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      prev_last  = o_last;
      if (o_done) begin
        done_cyc = n;
        break;
      end
    end
    i_start = 1'b0;
    $display("drain start=%03h end=%03h words=%0d done_cycle=%0d", sa, ea, words.size(), done_cyc);
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; i_start_addr = '0; i_end_addr = '0; i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++; if (o_rd_en !== 1'b0)   begin bad++; $display("FAIL reset_rd_en got=%b exp=0", o_rd_en); end
    total++; if (o_rd_addr !== '0)   begin bad++; $display("FAIL reset_rd_addr got=%h exp=0", o_rd_addr); end
    total++; if ({o_valid, o_last, o_busy, o_done, o_err} !== 5'b0)
      begin bad++; $display("FAIL reset_flags got=%b exp=00000", {o_valid, o_last, o_busy, o_done, o_err}); end
    total++; if (o_data !== '0)      begin bad++; $display("FAIL reset_data got=%h exp=0", o_data); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    drain(16'h010, 16'h013, 0, 0, 0, 0);
    total++; if (done_cyc !== 7)  begin bad++; $display("FAIL basic_done_cycle got=%0d exp=7", done_cyc); end
    total++; if (first_rd !== 1)  begin bad++; $display("FAIL basic_first_read got=%0d exp=1", first_rd); end
    total++; if (first_val !== 3) begin bad++; $display("FAIL basic_first_valid got=%0d exp=3", first_val); end
    total++; if (words.size() !== 4) begin bad++; $display("FAIL basic_count got=%0d exp=4", words.size()); end
    total++; if (rd_addrs.size() !== 4) begin bad++; $display("FAIL basic_reads got=%0d exp=4", rd_addrs.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < words.size()) begin
        total++; if (words[i] !== mem[16 + i])
          begin bad++; $display("FAIL basic_word%0d got=%h exp=%h", i, words[i], mem[16 + i]); end
        total++; if (lasts[i] !== (i == 3))
          begin bad++; $display("FAIL basic_last%0d got=%b exp=%b", i, lasts[i], (i == 3)); end
      end
      if (i < rd_addrs.size()) begin
        total++; if (rd_addrs[i] !== 16 + i)
          begin bad++; $display("FAIL basic_addr%0d got=%h exp=%h", i, rd_addrs[i], 16 + i); end
      end
    end
  endtask

  task automatic test_backpressure();
    for (int rep = 0; rep < 3; rep++) begin
      int sa;
      sa = (rep == 0) ? 0 : int'($urandom_range(0, 1000));
      drain(sa, sa + 7, 1, 0, 0, 0);
      total++; if (done_cyc < 0) begin bad++; $display("FAIL bp_timeout rep=%0d got=none exp=done", rep); end
      total++; if (words.size() !== 8) begin bad++; $display("FAIL bp_count rep=%0d got=%0d exp=8", rep, words.size()); end
      total++; if (credit_viol !== 0) begin bad++; $display("FAIL bp_credit rep=%0d got=%0d exp=0", rep, credit_viol); end
      total++; if (stable_viol !== 0) begin bad++; $display("FAIL bp_stable rep=%0d got=%0d exp=0", rep, stable_viol); end
      total++; if (busy_viol !== 0) begin bad++; $display("FAIL bp_busy rep=%0d got=%0d exp=0", rep, busy_viol); end
      for (int i = 0; i < words.size() && i < 8; i++) begin
        total++; if (words[i] !== mem[sa + i] || lasts[i] !== (i == 7))
          begin bad++; $display("FAIL bp_word%0d rep=%0d got=%h/%b exp=%h/%b", i, rep, words[i], lasts[i], mem[sa + i], (i == 7)); end
      end
    end
  endtask

  task automatic test_boundary();
    drain(16'h3FF, 16'h3FF, 0, 0, 0, 0);
    total++; if (rd_addrs.size() !== 1) begin bad++; $display("FAIL bnd1_reads got=%0d exp=1", rd_addrs.size()); end
    total++; if (words.size() !== 1) begin bad++; $display("FAIL bnd1_count got=%0d exp=1", words.size()); end
    if (words.size() > 0) begin
      total++; if (words[0] !== mem[1023] || lasts[0] !== 1'b1)
        begin bad++; $display("FAIL bnd1_word got=%h/%b exp=%h/1", words[0], lasts[0], mem[1023]); end
    end
    drain(16'h3FC, 16'h3FF, 1, 0, 0, 0);
    total++; if (rd_addrs.size() !== 4) begin bad++; $display("FAIL bnd4_reads got=%0d exp=4", rd_addrs.size()); end
    for (int i = 0; i < rd_addrs.size() && i < 4; i++) begin
      total++; if (rd_addrs[i] !== 16'h3FC + i)
        begin bad++; $display("FAIL bnd4_addr%0d got=%h exp=%h", i, rd_addrs[i], 16'h3FC + i); end
    end
    for (int i = 0; i < words.size() && i < 4; i++) begin
      total++; if (words[i] !== mem[16'h3FC + i])
        begin bad++; $display("FAIL bnd4_word%0d got=%h exp=%h", i, words[i], mem[16'h3FC + i]); end
    end
    // a wrapped pointer must not read after the range finishes
    repeat (3) begin
      @(posedge clk); #2;
      total++; if (o_rd_en !== 1'b0) begin bad++; $display("FAIL bnd_wrap_read got=1 addr=%h exp=0", o_rd_addr); end
    end
  endtask

  task automatic test_error();
    int rd_cnt, busy_cnt, err_cnt;
    @(posedge clk); #1;
    i_start = 1'b1; i_start_addr = 10'd5; i_end_addr = 10'd4;
    @(posedge clk); #1;
    i_start = 1'b0;
    #1;
    total++; if (o_err !== 1'b1) begin bad++; $display("FAIL err_pulse got=%b exp=1", o_err); end
    rd_cnt = int'(o_rd_en); busy_cnt = int'(o_busy); err_cnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #2;
      rd_cnt += int'(o_rd_en); busy_cnt += int'(o_busy); err_cnt += int'(o_err);
    end
    total++; if (rd_cnt !== 0)   begin bad++; $display("FAIL err_reads got=%0d exp=0", rd_cnt); end
    total++; if (busy_cnt !== 0) begin bad++; $display("FAIL err_busy got=%0d exp=0", busy_cnt); end
    total++; if (err_cnt !== 0)  begin bad++; $display("FAIL err_width got=%0d extra cycles exp=0", err_cnt); end
  endtask

  task automatic test_ignore();
    drain(16'h040, 16'h047, 1, 3, 16'h100, 16'h101);
    total++; if (words.size() !== 8) begin bad++; $display("FAIL ign_count got=%0d exp=8", words.size()); end
    total++; if (rd_addrs.size() !== 8) begin bad++; $display("FAIL ign_reads got=%0d exp=8", rd_addrs.size()); end
    for (int i = 0; i < words.size() && i < 8; i++) begin
      total++; if (words[i] !== mem[16'h040 + i])
        begin bad++; $display("FAIL ign_word%0d got=%h exp=%h", i, words[i], mem[16'h040 + i]); end
    end
  endtask

  task automatic test_reset_mid();
    int fv;
    fv = -1;
    @(posedge clk); #1;
    i_start = 1'b1; i_start_addr = 10'h030; i_end_addr = 10'h037; i_ready = 1'b0;
    for (int n = 1; n <= 20 && fv < 0; n++) begin
      @(posedge clk); #1; i_start = 1'b0; #1;
      if (o_valid) fv = n;
    end
    total++; if (fv < 0) begin bad++; $display("FAIL rst_mid_valid got=none exp=valid"); end
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #2;
    total++; if ({o_rd_en, o_valid, o_last, o_busy, o_done, o_err} !== 6'b0)
      begin bad++; $display("FAIL rst_mid_flags got=%b exp=000000", {o_rd_en, o_valid, o_last, o_busy, o_done, o_err}); end
    total++; if (o_data !== '0 || o_rd_addr !== '0)
      begin bad++; $display("FAIL rst_mid_data got=%h/%h exp=0/0", o_data, o_rd_addr); end
    rst = 1'b0;
    drain(16'h020, 16'h021, 0, 0, 0, 0);
    total++; if (words.size() !== 2) begin bad++; $display("FAIL rst_fresh_count got=%0d exp=2", words.size()); end
    for (int i = 0; i < words.size() && i < 2; i++) begin
      total++; if (words[i] !== mem[16'h020 + i])
        begin bad++; $display("FAIL rst_fresh_word%0d got=%h exp=%h", i, words[i], mem[16'h020 + i]); end
    end
  endtask

  task automatic test_back_to_back();
    drain(16'h050, 16'h052, 0, 0, 0, 0);
    total++; if (done_cyc !== 6) begin bad++; $display("FAIL b2b_first_done got=%0d exp=6", done_cyc); end
    drain(16'h060, 16'h061, 0, 0, 0, 0);
    total++; if (first_rd !== 1) begin bad++; $display("FAIL b2b_first_read got=%0d exp=1", first_rd); end
    total++; if (done_cyc !== 5) begin bad++; $display("FAIL b2b_done got=%0d exp=5", done_cyc); end
    total++; if (words.size() !== 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", words.size()); end
    for (int i = 0; i < words.size() && i < 2; i++) begin
      total++; if (words[i] !== mem[16'h060 + i] || lasts[i] !== (i == 1))
        begin bad++; $display("FAIL b2b_word%0d got=%h/%b exp=%h/%b", i, words[i], lasts[i], mem[16'h060 + i], (i == 1)); end
    end
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = rnd_word();
    i_rd_data = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_boundary();
    test_error();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/down_sram_drain_reader.md
Name: down_sram_drain_reader

Overview:
- Read-side master for the systolic array's output ("down") SRAM bank.
- After a GEMM/DRAINSYS completes, it walks an inclusive address range and issues SRAM reads on the down read port.
- It absorbs the 1-cycle SRAM read latency and delivers each NUM_COL-wide result row on a valid/ready stream to the store/DMA path.
- It uses credit-based prefetch into a 2-entry buffer, so backpressure never loses data.

Parameters:
- NUM_COL, 8, result columns per SRAM word
- OUT_DATA_WIDTH, 32, bits per column result
- LOG2_SRAM_BANK_DEPTH, 10, SRAM address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_start  in  1  1-cycle pulse; launch a drain
- i_start_addr  in  LOG2_SRAM_BANK_DEPTH  first address; sampled with i_start
- i_end_addr  in  LOG2_SRAM_BANK_DEPTH  last address, inclusive; sampled with i_start
- o_rd_en  out  1  SRAM read enable (drives i_down_rd_en)
- o_rd_addr  out  LOG2_SRAM_BANK_DEPTH  SRAM read address
- i_rd_data  in  NUM_COL*OUT_DATA_WIDTH  SRAM read data; valid the cycle after o_rd_en
- o_valid  out  1  stream word valid
- i_ready  in  1  stream consumer ready
- o_data  out  NUM_COL*OUT_DATA_WIDTH  stream word
- o_last  out  1  qualifies the final word of the range
- o_busy  out  1  drain in progress
- o_done  out  1  1-cycle pulse; final word accepted
- o_err  out  1  1-cycle pulse; range rejected

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; buffer is emptied; the in-flight flag is cleared. Reset mid-drain discards all buffered and in-flight data. SRAM data returned in the cycle after reset is ignored.
- Handshake: a transfer occurs when o_valid && i_ready. o_data and o_last hold stable while o_valid && !i_ready.
- FSM states: IDLE, READ, FLUSH, DONE.
- IDLE:
  - On i_start with i_end_addr >= i_start_addr: latch the range, set rd_ptr = start, go to READ, set o_busy = 1 from the next cycle.
  - On i_start with i_end_addr < i_start_addr: pulse o_err the next cycle, issue no reads, stay in IDLE.
- i_start is ignored whenever o_busy = 1.
- READ:
  - Issue a read (o_rd_en = 1, o_rd_addr = rd_ptr) when buffer occupancy + in-flight - (pop this cycle) < 2.
  - On each issue, rd_ptr increments.
  - When the issued address equals end, go to FLUSH.
  - End detection uses equality, so end = 2^LOG2_SRAM_BANK_DEPTH-1 never wraps rd_ptr into a spurious read.
- Read pipeline: i_rd_data is captured into the 2-entry FIFO exactly 1 cycle after o_rd_en. The word carries a last tag set if its address == end. The head of the FIFO is presented registered on o_data/o_valid/o_last.
- FLUSH: no reads are issued. When the last-tagged word is accepted, go to DONE.
- DONE: pulse o_done for one cycle, clear o_busy, return to IDLE. A new i_start is accepted in the cycle after DONE.
- o_rd_en is 0 outside READ. o_rd_addr holds its last value when o_rd_en = 0.
- Latency: i_start sampled at edge T. First o_rd_en is in cycle T+1, and the first o_valid is in cycle T+3.
- Throughput: with i_ready held high, one word per cycle is sustained, and N words take N+3 cycles from start to done pulse.
- Backpressure: the credit rule guarantees the FIFO never overflows. The FIFO is never both full and receiving.
- Simultaneous push and pop on a full or one-entry FIFO is legal; occupancy is unchanged.
- Single-word range (start == end): exactly one read is issued, and that word has o_last = 1.

Test Plan:
- Basic drain: start=0x010, end=0x013, i_ready=1 → reads 0x010..0x013 in cycles T+1..T+4; o_valid in T+3..T+6 with data equal to the SRAM model contents in order; o_last only on the 4th word; o_done in T+7.
- Backpressure: start=0, end=7, i_ready toggling 1,0,0,1,… (random) → exactly 8 words in order, no duplicates or drops; o_rd_en never raised when occupancy+inflight = 2; o_data stable while stalled.
- Boundary: start=end=0x3FF (LOG2_SRAM_BANK_DEPTH=10) → exactly one read at 0x3FF, one word with o_last=1, rd_ptr wrap causes no extra read. Also start=0x3FC, end=0x3FF → 4 reads, none at 0x000.
- Error/ignore: start=5, end=4 → o_err pulse, o_rd_en never asserted, o_busy stays 0. i_start pulsed mid-drain → ignored, original range completes unchanged.
- Reset mid-operation: assert rst two cycles after the first o_valid with i_ready=0 → all outputs 0 next cycle. A subsequent drain start=0x20, end=0x21 produces exactly 2 fresh words and no stale data.
- Back-to-back: i_start issued in the cycle after o_done → second drain begins normally, and its first read occurs 1 cycle later.
